// File: rtl/seq_shift_add_mult.sv
// Sequential unsigned shift-and-add multiplier: one add/shift step per clock, 2*WIDTH-bit exact product.
// Optional MULT_ZERO_BYPASS_EN: a zero operand skips the iteration and completes in one cycle.
module seq_shift_add_mult #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   i1,
  input  logic [WIDTH-1:0]   i2,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] out
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_p_hi;
  logic [WIDTH-1:0]   r_q;
  logic [CW-1:0]      r_count;
  logic [2*WIDTH-1:0] r_out;

  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_shifted;
  logic               w_last;
  logic               w_zero_op;

  // Adder operands; bit WIDTH of w_sum is the adder's carry_out and is shifted in, never dropped.
  assign w_addend  = r_q[0] ? r_a : '0;
  assign w_sum     = {1'b0, r_p_hi} + {1'b0, w_addend};
  assign w_shifted = {w_sum, r_q[WIDTH-1:1]};
  assign w_last    = (r_count == CW'(WIDTH - 1));

`ifdef MULT_ZERO_BYPASS_EN
  assign w_zero_op = (i1 == '0) || (i2 == '0);
`else
  assign w_zero_op = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = w_zero_op ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_p_hi  <= '0;
      r_q     <= '0;
      r_count <= '0;
      r_out   <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= i1;
            r_q     <= i2;
            r_p_hi  <= '0;
            r_count <= '0;
            if (w_zero_op) begin
              r_out <= '0;
            end
          end
        end
        S_RUN: begin
          {r_p_hi, r_q} <= w_shifted;
          r_count       <= r_count + CW'(1);
          // The product is published on the same edge as the final step.
          if (w_last) begin
            r_out <= w_shifted;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);
  assign out  = r_out;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Self-checking bench for seq_shift_add_mult: table vectors, hand-written corner sequences,
// randomized operands against a plain-arithmetic reference, plus a WIDTH=16 instance.
module tb_seq_shift_add_mult;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  i1;
  logic [7:0]  i2;
  logic        busy;
  logic        done;
  logic [15:0] out;

  logic        start16;
  logic [15:0] a16;
  logic [15:0] b16;
  logic        busy16;
  logic        done16;
  logic [31:0] out16;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_shift_add_mult #(.WIDTH(8)) dut8 (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .i1   (i1),
    .i2   (i2),
    .busy (busy),
    .done (done),
    .out  (out)
  );

  seq_shift_add_mult #(.WIDTH(16)) dut16 (
    .clk  (clk),
    .rst  (rst),
    .start(start16),
    .i1   (a16),
    .i2   (b16),
    .busy (busy16),
    .done (done16),
    .out  (out16)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[8];

  // Reference latency: edges from acceptance to the done cycle.
  function automatic int exp_lat(input int w, input longint a, input longint b);
`ifdef MULT_ZERO_BYPASS_EN
    if (a == 0 || b == 0) return 1;
`endif
    return w + 1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp,
                        input string tag);
    logic [15:0] prev;
    int lat;
    int busy_cnt;
    bit stable;
    @(negedge clk);
    start = 1'b1; i1 = a; i2 = b; prev = out;
    @(negedge clk);
    start = 1'b0; i1 = 8'($urandom); i2 = 8'($urandom);
    lat = 1; busy_cnt = 0; stable = 1'b1;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      if (out !== prev) stable = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (busy) busy_cnt++;
    check({tag, " done"}, 64'(done), 64'd1);
    check({tag, " product"}, 64'(out), 64'(exp));
    check({tag, " latency"}, 64'(lat), 64'(exp_lat(8, longint'(a), longint'(b))));
    check({tag, " busy cycles"}, 64'(busy_cnt), 64'(exp_lat(8, longint'(a), longint'(b))));
    check({tag, " out stable in run"}, 64'(stable), 64'd1);
    $display("op %s: %0d*%0d -> %0d (expected %0d) latency %0d", tag, a, b, out, exp, lat);
    @(negedge clk);
    check({tag, " done one cycle"}, 64'(done), 64'd0);
    check({tag, " idle after done"}, 64'(busy), 64'd0);
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b);
    longint exp;
    int lat;
    exp = longint'(a) * longint'(b);
    @(negedge clk);
    start16 = 1'b1; a16 = a; b16 = b;
    @(negedge clk);
    start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
    lat = 1;
    while (!done16 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check("w16 done", 64'(done16), 64'd1);
    check("w16 product", 64'(out16), 64'(exp));
    check("w16 latency", 64'(lat), 64'(exp_lat(16, longint'(a), longint'(b))));
    $display("op w16: %0d*%0d -> %0d (expected %0d) latency %0d", a, b, out16, exp, lat);
    @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, " drained"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    int ndone;
    logic [7:0] ra;
    logic [7:0] rb;

    vecs[0] = '{8'd13,  8'd11,  16'd143};
    vecs[1] = '{8'd255, 8'd255, 16'd65025};
    vecs[2] = '{8'd6,   8'd7,   16'd42};
    vecs[3] = '{8'd0,   8'd77,  16'd0};
    vecs[4] = '{8'd1,   8'd255, 16'd255};
    vecs[5] = '{8'd128, 8'd2,   16'd256};
    vecs[6] = '{8'd170, 8'd85,  16'd14450};
    vecs[7] = '{8'd77,  8'd0,   16'd0};

    // Reset with a pending start: nothing may complete.
    rst = 1'b1; start = 1'b1; i1 = 8'd13; i2 = 8'd11;
    start16 = 1'b0; a16 = '0; b16 = '0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      check("reset no done", 64'(done), 64'd0);
    end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset out", 64'(out), 64'd0);
    check("reset out16", 64'(out16), 64'd0);

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // start held high: one result every WIDTH+2 cycles, DONE-cycle start ignored,
    // and a mid-run i1 change must not leak into the captured multiplicand.
    @(negedge clk);
    start = 1'b1; i1 = 8'd3; i2 = 8'd5;
    nd = 0;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      if (c == 3) i1 = 8'd7;
      if (c == 6) i1 = 8'd3;
      if (done) begin
        check("held start product", 64'(out), 64'd15);
        check("held start cadence", 64'(c), 64'(9 + 10 * nd));
        $display("op held-start: 3*5 -> %0d at cycle %0d", out, c);
        nd++;
      end
    end
    check("held start result count", 64'(nd), 64'd3);
    start = 1'b0;
    wait_idle("held start");

    // Reset four cycles into a run aborts it silently.
    @(negedge clk);
    start = 1'b1; i1 = 8'd200; i2 = 8'd100;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort no done", 64'(ndone), 64'd0);
    check("abort idle", 64'(busy), 64'd0);
    check("abort out", 64'(out), 64'd0);
    $display("op abort: 200*100 cut by reset, out %0d", out);
    run_op(8'd6, 8'd7, 16'd42, "after abort");

    // Randomized operands against the arithmetic model; every fourth has a zero operand.
    for (int t = 0; t < 12; t++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (t % 4 == 3) ra = 8'd0;
      run_op(ra, rb, 16'(longint'(ra) * longint'(rb)), $sformatf("rand%0d", t));
    end

    run16(16'd40000, 16'd3);
    run16(16'hFFFF, 16'hFFFF);
    for (int t = 0; t < 3; t++) begin
      run16(16'($urandom), 16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
